// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: round-robin arbiter sharing one SRAM bank between
// NumPorts requesters, plus a power-gating sequencer
// (ON -> DRAIN -> GATING -> OFF -> WAKING -> ON).
// Optional feature: define SRAM_BANK_ARBITER_STATS_EN to add per-port
// saturating grant counters on grant_cnt_o.
module sram_bank_arbiter #(
  parameter int unsigned NumWords  = 8192,
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumPorts-1:0]                req_i,
  input  logic [NumPorts-1:0]                we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
  input  logic [NumPorts-1:0][31:0]          wdata_i,
  input  logic [NumPorts-1:0][3:0]           be_i,
  output logic [NumPorts-1:0]                gnt_o,
  output logic [NumPorts-1:0]                rvalid_o,
  output logic [NumPorts-1:0][31:0]          rdata_o,
  output logic                               mem_req_o,
  output logic                               mem_we_o,
  output logic [AddrWidth-1:0]               mem_addr_o,
  output logic [31:0]                        mem_wdata_o,
  output logic [3:0]                         mem_be_o,
  input  logic [31:0]                        mem_rdata_i,
  input  logic                               sleep_req_i,
  output logic                               mem_pwrgate_no,
  input  logic                               mem_pwrgate_ack_ni,
  output logic                               sleep_o
`ifdef SRAM_BANK_ARBITER_STATS_EN
  ,
  output logic [NumPorts-1:0][31:0]          grant_cnt_o
`endif
);

  localparam int unsigned PtrWidth = $clog2(NumPorts);

  typedef enum logic [2:0] {
    StOn,
    StDrain,
    StGating,
    StOff,
    StWaking
  } state_e;

  state_e              state_q, state_d;
  logic [PtrWidth-1:0] ptr_q;
  logic [NumPorts-1:0] rvalid_q;

  logic                found;
  logic                grant_en;
  logic [PtrWidth-1:0] sel;
  logic [PtrWidth-1:0] cand;
  int unsigned         idx;

  // Round-robin pick: first requesting port after the last granted one.
  // Reset is folded into the enable so grants drop the instant rst_ni falls.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    idx      = 0;
    grant_en = (state_q == StOn) && rst_ni;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      idx  = (32'(ptr_q) + 32'd1 + i) % NumPorts;
      cand = PtrWidth'(idx);
      if (!found && grant_en && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Grant decode and forwarding of the winning port to the memory side.
  always_comb begin
    gnt_o       = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (found) begin
      gnt_o[sel]  = 1'b1;
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[sel];
      mem_addr_o  = addr_i[sel];
      mem_wdata_o = wdata_i[sel];
      mem_be_o    = be_i[sel];
    end
  end

  // Round-robin pointer and one-cycle response tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= PtrWidth'(NumPorts - 1);
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt_o;
      if (found) begin
        ptr_q <= sel;
      end
    end
  end

  // Route memory read data only to the port whose response is due.
  always_comb begin
    rvalid_o = rvalid_q;
    rdata_o  = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (rvalid_q[p]) begin
        rdata_o[p] = mem_rdata_i;
      end
    end
  end

  // Power sequencer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StOn;
    end else begin
      state_q <= state_d;
    end
  end

  // Power sequencer next state and power-side outputs.
  // A grant made in the last ON cycle returns its rvalid during DRAIN, so a
  // single DRAIN cycle always leaves nothing in flight.
  always_comb begin
    state_d        = state_q;
    mem_pwrgate_no = 1'b1;
    sleep_o        = 1'b0;
    case (state_q)
      StOn: begin
        if (sleep_req_i) state_d = StDrain;
      end
      StDrain: begin
        state_d = sleep_req_i ? StGating : StOn;
      end
      StGating: begin
        mem_pwrgate_no = 1'b0;
        if (!mem_pwrgate_ack_ni) state_d = StOff;
      end
      StOff: begin
        mem_pwrgate_no = 1'b0;
        sleep_o        = 1'b1;
        if (!sleep_req_i) state_d = StWaking;
      end
      StWaking: begin
        if (mem_pwrgate_ack_ni) state_d = StOn;
      end
      default: state_d = StOn;
    endcase
  end

`ifdef SRAM_BANK_ARBITER_STATS_EN
  logic [NumPorts-1:0][31:0] grant_cnt_q;

  // Per-port saturating grant counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (gnt_o[p] && (grant_cnt_q[p] != '1)) begin
          grant_cnt_q[p] <= grant_cnt_q[p] + 32'd1;
        end
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Testbench for sram_bank_arbiter: directed power-sequence steps plus a
// randomized traffic phase checked against a behavioural reference model.
module tb_sram_bank_arbiter;

  localparam int unsigned NW = 8192;
  localparam int unsigned NP = 3;
  localparam int unsigned AW = $clog2(NW);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NP-1:0]          req, we;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][31:0]    wdata;
  logic [NP-1:0][3:0]     be;
  logic [NP-1:0]          gnt, rvalid;
  logic [NP-1:0][31:0]    rdata;
  logic                   mem_req, mem_we;
  logic [AW-1:0]          mem_addr;
  logic [31:0]            mem_wdata, mem_rdata;
  logic [3:0]             mem_be;
  logic                   sleep_req, pwrgate_n, ack_n, sleep;
`ifdef SRAM_BANK_ARBITER_STATS_EN
  logic [NP-1:0][31:0]    grant_cnt;
`endif

  int ncmp  = 0;
  int nfail = 0;

  logic [31:0] env_mem [32];
  logic [31:0] ref_mem [32];
  int          last;
  int          pend;
  logic [31:0] pdata;

  always #5 clk = ~clk;

  sram_bank_arbiter #(
    .NumWords(NW),
    .NumPorts(NP)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .req_i             (req),
    .we_i              (we),
    .addr_i            (addr),
    .wdata_i           (wdata),
    .be_i              (be),
    .gnt_o             (gnt),
    .rvalid_o          (rvalid),
    .rdata_o           (rdata),
    .mem_req_o         (mem_req),
    .mem_we_o          (mem_we),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_be_o          (mem_be),
    .mem_rdata_i       (mem_rdata),
    .sleep_req_i       (sleep_req),
    .mem_pwrgate_no    (pwrgate_n),
    .mem_pwrgate_ack_ni(ack_n),
    .sleep_o           (sleep)
`ifdef SRAM_BANK_ARBITER_STATS_EN
    ,
    .grant_cnt_o       (grant_cnt)
`endif
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM macro stand-in: read data one cycle after the request.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= '0;
    end else if (mem_req) begin
      mem_rdata <= env_mem[mem_addr[4:0]];
      if (mem_we) env_mem[mem_addr[4:0]] <= merge(env_mem[mem_addr[4:0]], mem_wdata, mem_be);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    sleep_req = 1'b0; ack_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.gnt", gnt, 0);
    check("rst.rvalid", rvalid, 0);
    check("rst.rdata", rdata, 0);
    check("rst.mem_req", mem_req, 0);
    check("rst.pwrgate_n", pwrgate_n, 1);
    check("rst.sleep", sleep, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last = NP - 1;
    pend = -1;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
  endtask

  // One clock cycle: en says whether the bank should be accepting grants.
  task automatic cyc(input bit en, input string tag);
    int w;
    int p;
    logic [NP-1:0] eg, ev;
    #1;
    w = -1;
    if (en) begin
      for (int i = 0; i < NP; i++) begin
        p = (last + 1 + i) % NP;
        if (w < 0 && req[p]) w = p;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    check({tag, ".gnt"}, gnt, eg);
    check({tag, ".mem_req"}, mem_req, (w >= 0));
    check({tag, ".mem_we"}, mem_we, (w >= 0) ? we[w] : 1'b0);
    check({tag, ".mem_be"}, mem_be, (w >= 0) ? be[w] : 4'h0);
    if (w >= 0) begin
      check({tag, ".mem_addr"}, mem_addr, addr[w]);
      check({tag, ".mem_wdata"}, mem_wdata, wdata[w]);
    end
    @(posedge clk);
    if (w >= 0) begin
      last  = w;
      pend  = w;
      pdata = ref_mem[addr[w][4:0]];
      if (we[w]) ref_mem[addr[w][4:0]] = merge(ref_mem[addr[w][4:0]], wdata[w], be[w]);
    end else begin
      pend = -1;
    end
    @(negedge clk);
    ev = '0;
    if (pend >= 0) ev[pend] = 1'b1;
    check({tag, ".rvalid"}, rvalid, ev);
    for (int q = 0; q < NP; q++)
      check({tag, ".rdata"}, rdata[q], (pend == q) ? pdata : 32'h0);
  endtask

  initial begin
    do_reset();

    // Two continuous requesters alternate 0,1,0,1.
    req = 3'b011; we = '0; addr = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("alt.seq", gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
      cyc(1, "alt");
    end

    // Partial write merges with existing word.
    req = 3'b001; we = 3'b001; addr[0] = AW'(16); wdata[0] = 32'h11223344; be[0] = 4'hF;
    cyc(1, "wr_full");
    req = 3'b010; we = 3'b010; addr[1] = AW'(16); wdata[1] = 32'hDEADBEEF; be[1] = 4'h3;
    cyc(1, "wr_part");
    req = 3'b001; we = 3'b000; addr[0] = AW'(16);
    cyc(1, "rd_merge");
    check("rd_merge.const", rdata[0], 32'h1122BEEF);

    // Sleep request alongside a read: grant now, gate two cycles later.
    req = 3'b001; we = '0; addr[0] = AW'(16); sleep_req = 1'b1;
    cyc(1, "slp_grant");
    check("slp.drain_pwr", pwrgate_n, 1);
    req = 3'b010;
    cyc(0, "slp_drain");
    check("slp.gating_pwr", pwrgate_n, 0);
    cyc(0, "slp_gating");
    check("slp.gating_sleep", sleep, 0);
    ack_n = 1'b0;
    cyc(0, "slp_ack");
    check("slp.off_sleep", sleep, 1);
    check("slp.off_pwr", pwrgate_n, 0);
    cyc(0, "slp_off");

    // Wake: pending port 1 held off until ON, then granted first.
    sleep_req = 1'b0;
    cyc(0, "wake0");
    check("wake.pwr", pwrgate_n, 1);
    check("wake.sleep", sleep, 0);
    cyc(0, "wake1");
    cyc(0, "wake2");
    ack_n = 1'b1;
    cyc(0, "wake_ack");
    cyc(1, "wake_on");

    // Sleep dropped in DRAIN returns to ON without gating.
    req = 3'b001; sleep_req = 1'b1;
    cyc(1, "drp_grant");
    sleep_req = 1'b0;
    cyc(0, "drp_drain");
    check("drp.pwr", pwrgate_n, 1);
    cyc(1, "drp_on");

    // Sleep dropped in GATING still completes OFF, then wakes.
    req = '0; sleep_req = 1'b1;
    cyc(1, "gdp_on");
    cyc(0, "gdp_drain");
    sleep_req = 1'b0;
    cyc(0, "gdp_gating");
    check("gdp.pwr", pwrgate_n, 0);
    ack_n = 1'b0;
    cyc(0, "gdp_ack");
    check("gdp.off", sleep, 1);
    cyc(0, "gdp_off");
    check("gdp.waking_pwr", pwrgate_n, 1);
    ack_n = 1'b1;
    cyc(0, "gdp_waking");
    req = 3'b100;
    cyc(1, "gdp_on2");

    // Randomized traffic, bank always powered.
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NP; p++) begin
        req[p]   = ($urandom_range(0, 3) != 0);
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = AW'($urandom_range(0, 31));
        wdata[p] = $urandom;
        be[p]    = 4'($urandom_range(0, 15));
      end
      cyc(1, "rand");
    end

    // Asynchronous reset while GATING.
    req = '0; sleep_req = 1'b1;
    cyc(1, "ar_on");
    cyc(0, "ar_drain");
    check("ar.gating", pwrgate_n, 0);
    req = 3'b001;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.pwr", pwrgate_n, 1);
    check("ar.gnt", gnt, 0);
    check("ar.mem_req", mem_req, 0);
    check("ar.mem_be", mem_be, 0);
    check("ar.rvalid", rvalid, 0);
    check("ar.sleep", sleep, 0);
    do_reset();

    // Reset discards a pending response.
    req = 3'b001; we = '0; addr[0] = AW'(3);
    #1;
    check("rd.gnt", gnt, 3'b001);
    @(posedge clk);
    #1;
    check("rd.rvalid_set", rvalid, 3'b001);
    rst_n = 1'b0;
    #1;
    check("rd.rvalid_clr", rvalid, 0);
    check("rd.rdata_clr", rdata, 0);
    do_reset();

`ifdef SRAM_BANK_ARBITER_STATS_EN
    req = 3'b010;
    repeat (5) cyc(1, "cnt");
    req = '0;
    cyc(1, "cnt_idle");
    check("cnt.p1", grant_cnt[1], 5);
    check("cnt.p0", grant_cnt[0], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

Interface
REQ-001 SHALL have parameter NumWords, default 8192, words in the shared SRAM bank.
REQ-002 SHALL have parameter NumPorts, default 2, legal range 2..4, number of requesters.
REQ-003 SHALL have derived parameter AddrWidth, default $clog2(NumWords), word address width; it is not overridden.
REQ-004 SHALL have: clk_i  in  1  sole clock.
REQ-005 SHALL have: rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have, per port p: req_i, we_i  in  NumPorts  request and write enable.
REQ-007 SHALL have, per port p: addr_i  in  NumPorts x AddrWidth; wdata_i  in  NumPorts x 32; be_i  in  NumPorts x 4.
REQ-008 SHALL have, per port p: gnt_o, rvalid_o  out  NumPorts; rdata_o  out  NumPorts x 32.
REQ-009 SHALL have memory side: mem_req_o, mem_we_o  out  1; mem_addr_o  out  AddrWidth; mem_wdata_o  out  32; mem_be_o  out  4; mem_rdata_i  in  32, valid 1 cycle after mem_req_o.
REQ-010 SHALL have power side: sleep_req_i  in  1  request to gate the bank; mem_pwrgate_no  out  1  to the macro; mem_pwrgate_ack_ni  in  1  from the macro; sleep_o  out  1  bank gated.

Function
REQ-011 SHALL grant at most one port per cycle: gnt_o[p] combinational, same cycle as req_i[p], only in state ON.
REQ-012 SHALL arbitrate round-robin: search starts at the port after the last granted port; pointer updates only on a grant.
REQ-013 SHALL drive mem_req_o=1 and forward the granted port's we/addr/wdata/be; mem_be_o and mem_we_o SHALL be 0 when no port is granted.
REQ-014 SHALL assert rvalid_o[p] exactly 1 cycle after gnt_o[p], for reads and writes; rdata_o[p]=mem_rdata_i then, 0 otherwise.
REQ-015 SHALL support back-to-back grants, one per cycle, with no bubble.
REQ-016 SHALL implement FSM ON -> DRAIN -> GATING -> OFF -> WAKING -> ON.
REQ-017 ON: on sleep_req_i=1 go to DRAIN; grants still occur in that same cycle.
REQ-018 DRAIN: no grants; go to GATING once no rvalid is pending (at most 1 cycle).
REQ-019 GATING: mem_pwrgate_no=0; go to OFF when mem_pwrgate_ack_ni=0.
REQ-020 OFF: sleep_o=1; on sleep_req_i=0 go to WAKING with mem_pwrgate_no=1.
REQ-021 WAKING: no grants; go to ON when mem_pwrgate_ack_ni=1.
REQ-022 If sleep_req_i drops during DRAIN, SHALL return to ON; if it drops during GATING, SHALL continue to OFF and then wake.
REQ-023 Requests outside ON SHALL be held off, gnt_o=0; none are dropped or reordered per port.

Reset
REQ-024 Reset SHALL set: state ON; RR pointer so port 0 has top priority; gnt_o=0, rvalid_o=0, rdata_o=0, mem_req_o=0, mem_pwrgate_no=1, sleep_o=0.
REQ-025 Reset mid-transaction SHALL discard any pending rvalid; a gated bank re-powers from reset state (mem_pwrgate_no=1).

Configuration
REQ-026 Macro SRAM_BANK_ARBITER_STATS_EN defined: SHALL add output grant_cnt_o, NumPorts x 32, per-port saturating grant counters, reset 0.
REQ-027 Macro undefined: SHALL have no grant_cnt_o port and no counter logic.

Verification
REQ-028 Port 0 and port 1 both request continuously after reset -> grants alternate 0,1,0,1; each rvalid_o follows its grant 1 cycle later.
REQ-029 Port 1 writes 0xDEADBEEF with be=0x3 to addr 0x10, then port 0 reads 0x10 -> read returns bytes [15:0]=0xBEEF, upper bytes unchanged.
REQ-030 sleep_req_i=1 in the same cycle as a port 0 read -> read granted, rvalid next cycle; mem_pwrgate_no=0 two cycles after; sleep_o=1 the cycle after ack=0.
REQ-031 sleep_req_i deasserted in OFF, ack returns 3 cycles later -> no grant before state ON; the pending req_i is granted the first cycle in ON.
REQ-032 rst_ni=0 asserted during GATING -> mem_pwrgate_no=1 and all outputs 0 immediately, asynchronously.
REQ-033 With SRAM_BANK_ARBITER_STATS_EN, 5 grants to port 1 -> grant_cnt_o[1]=5, grant_cnt_o[0]=0.
